// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IMEM_DEPTH_WORDS : instruction RAM capacity in words (IM decodes Address[9:2])
//   RESET_PC         : CPU reset PC; the first word is written here
//   loader_state_e   : loader FSM state encoding
package imem_loader_pkg;

    localparam int unsigned IMEM_DEPTH_WORDS = 256;
    localparam logic [31:0] RESET_PC         = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StChk,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   clear       : restart at byte 0 of a new word (drops any pending strobe)
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : stream byte, MSB-first within each word
//   last_byte   : the byte consumed this cycle completes a word
//   word_valid  : one-cycle strobe, the cycle after the 4th byte
//   word        : last completed word (held until the next one completes)
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;
    logic [31:0] word_q;
    logic        valid_q;

    assign last_byte  = (cnt_q == 2'd3);
    assign word_valid = valid_q;
    assign word       = word_q;

    // The first three bytes sit in shift_q; the fourth lands straight in word_q, so the
    // output word stays stable while the next word starts shifting in.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'h0;
            word_q  <= 32'h0;
            valid_q <= 1'b0;
        end else if (clear) begin
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= byte_valid && last_byte;
            if (byte_valid) begin
                cnt_q   <= cnt_q + 2'd1;
                shift_q <= {shift_q[15:0], byte_data};
                if (last_byte) begin
                    word_q <= {shift_q, byte_data};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM loader: receives a length-prefixed byte stream, writes big-endian words to
// consecutive word addresses from BASE_ADDR and holds the CPU while doing so.
// Frame: LEN_HI, LEN_LO (word count N), N x 4 data bytes [, checksum byte].
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR-of-data-bytes checksum.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : pulse, begins a session from IDLE/DONE/ERR
//   rx_data/rx_valid/rx_ready : byte stream handshake
//   mem_we/mem_addr/mem_wdata : instruction RAM write port
//   cpu_hold     : stall/flush the CPU while high
//   done/error   : status of the last session
//   words_loaded : words written in the current/last session
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    loader_state_e state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   words_q, words_d;
    logic [31:0]   addr_q, addr_d;
    logic          rx_fire, data_fire, start_ok, last_byte, word_done;
    logic [15:0]   len_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
    logic [7:0] chk_q;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            chk_q <= 8'h00;
        end else if (data_fire) begin
            chk_q <= chk_q ^ rx_data;
        end
    end
`else
    localparam bit ChkEn = 1'b0;
    logic [7:0] chk_q;
    assign chk_q = 8'h00;
`endif

    assign rx_fire   = rx_valid && rx_ready;
    assign data_fire = rx_fire && (state_q == StData);
    assign word_done = data_fire && last_byte;
    assign start_ok  = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign len_full  = {len_q[15:8], rx_data};

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (data_fire),
        .byte_data  (rx_data),
        .last_byte  (last_byte),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

    always_comb begin
        unique case (state_q)
            StLenHi, StLenLo, StChk: rx_ready = 1'b1;
            // Stop accepting once every data byte has arrived; the final write still pends.
            StData:                  rx_ready = (words_q != len_q);
            default:                 rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        addr_d  = addr_q;
        // words_loaded counts a word at its 4th byte so it reads k+1 during that word's strobe.
        if (word_done) begin
            words_d = words_q + 16'd1;
        end
        if (mem_we) begin
            addr_d = addr_q + 32'd4;
        end
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLenHi;
                    words_d = 16'd0;
                    addr_d  = BASE_ADDR;
                end
            end
            StLenHi: begin
                if (rx_fire) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (rx_fire) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = ChkEn ? StChk : StDone;
                    end else if ({16'h0, len_full} > DEPTH_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (ChkEn && word_done && (words_q + 16'd1 == len_q)) begin
                    state_d = StChk;
                end else if (!ChkEn && mem_we && (words_q == len_q)) begin
                    // Last word strobing this cycle; leave hold asserted through it.
                    state_d = StDone;
                end
            end
            StChk: begin
                if (rx_fire) begin
                    state_d = (rx_data == chk_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= 16'd0;
            words_q <= 16'd0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_addr     = addr_q;
    assign words_loaded = words_q;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);
    assign cpu_hold     = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData) ||
                          (state_q == StChk) || (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader. Build with +define+IMEM_LOADER_CHECKSUM_EN
// to exercise the checksum variant.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, rx_valid, rx_ready, mem_we, cpu_hold, done, error;
    logic [7:0]  rx_data;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_loaded;

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] wl;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            check("we_expected", 32'(exp_q.size() != 0), 1);
            check("hold_during_we", 32'(cpu_hold), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("we_addr", mem_addr, e.addr);
                check("we_data", mem_wdata, e.data);
                check("we_words_loaded", 32'(words_loaded), 32'(e.wl));
            end
        end
    end

    // Tasks are entered and left 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("hold_after_start", 32'(cpu_hold), 1);
        check("start_clears_status", {30'h0, done, error}, 0);
        check("start_clears_count", 32'(words_loaded), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        bit ok = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!ok && waited < 20) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk); #1;
            waited++;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) check("rx_ready_timeout", 32'(ok), 1);
    endtask

    // Reference: N words go to BASE+4i in order; N==0 completes at once, N>DEPTH errors
    // after the length; with checksum, a wrong XOR byte errors after all writes.
    task automatic run_frame(input int n, input bit gaps, input bit corrupt);
        logic [15:0] len;
        logic [7:0]  chk, b;
        bit          exp_err;
        int          waited;
        wr_t         w;
        len     = 16'(n);
        chk     = 8'h00;
        exp_err = (n > int'(DEPTH));
        pulse_start();
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                w.addr = BASE + 32'(4 * i);
                w.data = words[i];
                w.wl   = 16'(i + 1);
                exp_q.push_back(w);
            end
            for (int i = 0; i < n; i++) begin
                for (int j = 3; j >= 0; j--) begin
                    b   = words[i][8*j +: 8];
                    chk = chk ^ b;
                    send_byte(b, gaps);
                end
            end
            if (ChkEn) begin
                send_byte(corrupt ? (chk ^ 8'h01) : chk, gaps);
                exp_err = corrupt;
            end
        end
        waited = 0;
        @(negedge clk);
        if (n == 0 && !ChkEn) check("len0_done_next_cycle", 32'(done), 1);
        while (!(done || error) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("end_done", 32'(done), 32'(!exp_err));
        check("end_error", 32'(error), 32'(exp_err));
        check("end_hold", 32'(cpu_hold), 32'(exp_err));
        check("end_words_loaded", 32'(words_loaded), (n > int'(DEPTH)) ? 0 : 32'(n));
        check("end_addr", mem_addr, (n > int'(DEPTH)) ? BASE : BASE + 32'(4 * n));
        check("all_writes_seen", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(rx_ready), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 0);
        check("rst_status", {29'h0, cpu_hold, done, error}, 0);
        check("rst_words", 32'(words_loaded), 0);
        @(posedge clk); #1;

        // Directed frame, then the same with random stalls.
        words.delete();
        words.push_back(32'h2004_0000);
        words.push_back(32'h2005_0003);
        run_frame(2, 1'b0, 1'b0);
        run_frame(2, 1'b1, 1'b0);
        // Empty frame and over-length frame, then recovery.
        run_frame(0, 1'b0, 1'b0);
        run_frame(257, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        // Checksum mismatch (plain frame when the feature is absent).
        run_frame(2, 1'b0, 1'b1);

        // Reset after the 2nd byte of word 1 abandons the session.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h04, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(rx_ready), 0);
        check("midrst_we", 32'(mem_we), 0);
        check("midrst_addr", mem_addr, BASE);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_status", {29'h0, cpu_hold, done, error}, 0);
        check("midrst_words", 32'(words_loaded), 0);
        @(posedge clk); #1;
        run_frame(2, 1'b0, 1'b0);

        // Capacity boundary.
        rand_words(256);
        run_frame(256, 1'b0, 1'b0);

        // Randomized frames.
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) n = $urandom_range(257, 400);
            rand_words(n);
            run_frame(n, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
